// File: rtl/mc_pkg.sv
// Shared definitions for the Monte Carlo reduction datapath: state encoding,
// Q8.8 format constants and the Q16.16 -> Q8.8 shift/saturate helper.
package mc_pkg;

  typedef enum logic [1:0] {
    PA_IDLE  = 2'd0,
    PA_ACCUM = 2'd1,
    PA_MEAN  = 2'd2,
    PA_SCALE = 2'd3
  } pa_state_t;

  localparam int          Q_FRAC = 8;
  localparam logic [15:0] Q_ONE  = 16'h0100;
  localparam logic [15:0] SAT16  = 16'hFFFF;

  // Drops the extra fraction bits of a Q16.16 value and clamps the result to Q8.8 range.
  function automatic logic [15:0] q88_shift_sat(input logic [31:0] p);
    logic [31:0] shifted;
    shifted = p >> Q_FRAC;
    if (shifted[31:16] != 16'h0000) return SAT16;
    else                            return shifted[15:0];
  endfunction

endpackage

// File: rtl/q88_mul_sat.sv
// Unsigned Q8.8 x Q8.8 multiply, rescaled back to Q8.8 and saturated to 16 bits.
module q88_mul_sat
  import mc_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  logic [31:0] p;

  assign p = {16'h0000, a} * {16'h0000, b};
  assign y = q88_shift_sat(p);

endmodule

// File: rtl/payoff_accumulator.sv
// Sums 2^LOG2_N Q8.8 payoffs, takes the mean and discounts it into a price.
// Optional sample variance output when PAYOFF_VAR_EN is defined.
module payoff_accumulator
  import mc_pkg::*;
#(
  parameter int LOG2_N = 10
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       disc,
  input  logic              sample_valid,
  input  logic [15:0]       val,
  output logic              busy,
  output logic              done,
  output logic [15:0]       price,
  output logic [LOG2_N-1:0] count
`ifdef PAYOFF_VAR_EN
  ,
  output logic [15:0]       var_out
`endif
);

  localparam logic [LOG2_N-1:0] CNT_ONE  = 1;
  localparam logic [LOG2_N-1:0] CNT_LAST = '1;

  pa_state_t            state, state_nxt;
  logic [16+LOG2_N-1:0] acc;
  logic [15:0]          disc_r;
  logic [15:0]          mean_r;
  logic [15:0]          price_nxt;

  q88_mul_sat u_disc_mul (
    .a (mean_r),
    .b (disc_r),
    .y (price_nxt)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= PA_IDLE;
    else         state <= state_nxt;
  end

  // NOTE: default assigned first so every path through the case is covered and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      PA_IDLE:  if (start) state_nxt = PA_ACCUM;
      PA_ACCUM: begin
        if (abort)                                  state_nxt = PA_IDLE;
        else if (sample_valid && count == CNT_LAST) state_nxt = PA_MEAN;
      end
      PA_MEAN:  state_nxt = abort ? PA_IDLE : PA_SCALE;
      PA_SCALE: state_nxt = PA_IDLE;
      default:  state_nxt = PA_IDLE;
    endcase
  end

  assign busy = (state != PA_IDLE);

  // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      acc    <= '0;
      count  <= '0;
      disc_r <= '0;
      mean_r <= '0;
      price  <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        PA_IDLE: if (start) begin
          acc    <= '0;
          count  <= '0;
          disc_r <= disc;
        end
        PA_ACCUM: if (!abort && sample_valid) begin
          acc   <= acc + {{LOG2_N{1'b0}}, val};
          count <= count + CNT_ONE;
        end
        PA_MEAN:  if (!abort) mean_r <= acc[LOG2_N +: 16];
        PA_SCALE: if (!abort) begin
          price <= price_nxt;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef PAYOFF_VAR_EN
  logic [32+LOG2_N-1:0] sq_acc;
  logic [31:0]          m2_r;
  logic [31:0]          mean_sq;
  logic [31:0]          var_q16;

  assign mean_sq = {16'h0000, mean_r} * {16'h0000, mean_r};
  // E[x^2] - E[x]^2 can dip below zero through truncation; clamp rather than wrap.
  assign var_q16 = (m2_r > mean_sq) ? (m2_r - mean_sq) : 32'h0000_0000;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sq_acc  <= '0;
      m2_r    <= '0;
      var_out <= '0;
    end else begin
      case (state)
        PA_IDLE:  if (start) sq_acc <= '0;
        PA_ACCUM: if (!abort && sample_valid)
          sq_acc <= sq_acc + {{LOG2_N{1'b0}}, {16'h0000, val} * {16'h0000, val}};
        PA_MEAN:  if (!abort) m2_r <= sq_acc[LOG2_N +: 32];
        PA_SCALE: if (!abort) var_out <= q88_shift_sat(var_q16);
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_payoff_accumulator.sv
// Directed self-checking bench for payoff_accumulator at LOG2_N=2.
module tb_payoff_accumulator;
  import mc_pkg::*;

  localparam int LOG2_N = 2;

  logic              clk = 1'b0;
  logic              nreset = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [15:0]       disc = 16'h0000;
  logic              sample_valid = 1'b0;
  logic [15:0]       val = 16'h0000;
  logic              busy;
  logic              done;
  logic [15:0]       price;
  logic [LOG2_N-1:0] count;
`ifdef PAYOFF_VAR_EN
  logic [15:0]       var_out;
`endif

  int checks = 0;
  int failures = 0;

  payoff_accumulator #(.LOG2_N(LOG2_N)) dut (
    .clk          (clk),
    .nreset       (nreset),
    .start        (start),
    .abort        (abort),
    .disc         (disc),
    .sample_valid (sample_valid),
    .val          (val),
    .busy         (busy),
    .done         (done),
    .price        (price),
    .count        (count)
`ifdef PAYOFF_VAR_EN
    ,
    .var_out      (var_out)
`endif
  );

  always #5 clk = ~clk;

  // All stimulus helpers begin and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] d);
    start = 1'b1;
    disc  = d;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] v);
    sample_valid = 1'b1;
    val          = v;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic run4(input logic [15:0] d, input logic [15:0] v0, input logic [15:0] v1,
                      input logic [15:0] v2, input logic [15:0] v3);
    do_start(d);
    feed(v0);
    feed(v1);
    feed(v2);
    feed(v3);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    #3;
    checks++;
    if ({busy, done, price, count} !== {1'b0, 1'b0, 16'h0000, {LOG2_N{1'b0}}}) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b price=%h count=%0d, want 0 0 0000 0",
               busy, done, price, count);
    end
`ifdef PAYOFF_VAR_EN
    checks++;
    if (var_out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_var: var_out=%h want 0000", var_out);
    end
`endif
    nreset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    run4(Q_ONE, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL basic_latency_c%0d: done=%b busy=%b want 0 1", c, done, busy);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_cycle: done=%b busy=%b want 1 0", done, busy);
    end
    checks++;
    if (price !== 16'h0280) begin
      failures++;
      $display("FAIL basic_price: price=%h want 0280", price);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse: done=%b want 0", done);
    end
  endtask

  task automatic test_abort();
    bit saw_done;
    bit ok;
    do_start(Q_ONE);
    feed(16'h0400);
    feed(16'h0400);
    start = 1'b1;
    disc  = 16'h0000;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || count !== 2'd2) begin
      failures++;
      $display("FAIL busy_start_ignored: busy=%b count=%0d want 1 2", busy, count);
    end
    abort = 1'b1;
    sample_valid = 1'b1;
    val = 16'h0400;
    step();
    abort = 1'b0;
    sample_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || price !== 16'h0280) begin
      failures++;
      $display("FAIL abort_state: busy=%b price=%h want 0 0280", busy, price);
    end
    saw_done = done;
    for (int i = 0; i < 4; i++) begin
      step();
      saw_done = saw_done | done;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done: done seen=%b want 0", saw_done);
    end
    run4(Q_ONE, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    wait_done(10, ok);
    checks++;
    if (!ok || price !== 16'h0100) begin
      failures++;
      $display("FAIL after_abort_price: done_seen=%b price=%h want 1 0100", ok, price);
    end
  endtask

  task automatic test_gaps();
    bit ok;
    logic [15:0] vals [4];
    vals = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    do_start(16'h0080);
    for (int i = 0; i < 4; i++) begin
      feed(vals[i]);
      checks++;
      if (count !== 2'(i + 1)) begin
        failures++;
        $display("FAIL gap_count_%0d: count=%0d want %0d", i, count, 2'(i + 1));
      end
      if (i < 3) begin
        step();
        step();
      end
    end
    wait_done(10, ok);
    checks++;
    if (!ok || price !== 16'h0140) begin
      failures++;
      $display("FAIL gap_price: done_seen=%b price=%h want 1 0140", ok, price);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    run4(16'h0200, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    wait_done(10, ok);
    checks++;
    if (!ok || price !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_price: done_seen=%b price=%h want 1 ffff", ok, price);
    end
    run4(16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    wait_done(10, ok);
    checks++;
    if (!ok || price !== 16'h0000) begin
      failures++;
      $display("FAIL zero_disc_price: done_seen=%b price=%h want 1 0000", ok, price);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    run4(Q_ONE, 16'h0300, 16'h0300, 16'h0300, 16'h0300);
    wait_done(10, ok);
    do_start(Q_ONE);
    feed(16'h0100);
    feed(16'h0100);
    #2;
    nreset = 1'b0;
    #1;
    checks++;
    if ({busy, done, price, count} !== {1'b0, 1'b0, 16'h0000, {LOG2_N{1'b0}}}) begin
      failures++;
      $display("FAIL midrun_reset: busy=%b done=%b price=%h count=%0d want 0 0 0000 0",
               busy, done, price, count);
    end
    nreset = 1'b1;
    step();
    run4(Q_ONE, 16'h0200, 16'h0200, 16'h0200, 16'h0200);
    wait_done(10, ok);
    checks++;
    if (!ok || price !== 16'h0200) begin
      failures++;
      $display("FAIL post_reset_price: done_seen=%b price=%h want 1 0200", ok, price);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    run4(Q_ONE, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    wait_done(10, ok);
    checks++;
    if (!ok || price !== 16'h0100) begin
      failures++;
      $display("FAIL b2b_first: done_seen=%b price=%h want 1 0100", ok, price);
    end
    do_start(16'h0300);
    checks++;
    if (busy !== 1'b1 || count !== 2'd0) begin
      failures++;
      $display("FAIL b2b_start_accepted: busy=%b count=%0d want 1 0", busy, count);
    end
    feed(16'h0200);
    feed(16'h0200);
    checks++;
    if (price !== 16'h0100) begin
      failures++;
      $display("FAIL b2b_price_held: price=%h want 0100", price);
    end
    feed(16'h0200);
    feed(16'h0200);
    wait_done(10, ok);
    checks++;
    if (!ok || price !== 16'h0600) begin
      failures++;
      $display("FAIL b2b_second: done_seen=%b price=%h want 1 0600", ok, price);
    end
  endtask

`ifdef PAYOFF_VAR_EN
  task automatic test_variance();
    bit ok;
    run4(Q_ONE, 16'h0100, 16'h0300, 16'h0100, 16'h0300);
    wait_done(10, ok);
    checks++;
    if (!ok || price !== 16'h0200 || var_out !== 16'h0100) begin
      failures++;
      $display("FAIL var_spread: done_seen=%b price=%h var=%h want 1 0200 0100", ok, price, var_out);
    end
    run4(Q_ONE, 16'h0180, 16'h0180, 16'h0180, 16'h0180);
    wait_done(10, ok);
    checks++;
    if (!ok || var_out !== 16'h0000) begin
      failures++;
      $display("FAIL var_const: done_seen=%b var=%h want 1 0000", ok, var_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_gaps();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
`ifdef PAYOFF_VAR_EN
    test_variance();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
